clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter W, default 16: divisor/counter width in bits (2..32).
REQ-003 Parameter RST_DIV, default 16384: divisor loaded into every channel at reset (gives 6103.5 Hz from 100 MHz).
REQ-004 clk  in  1: single clock; all logic on rising edge.
REQ-005 rst_n  in  1: reset, synchronous, active-low.
REQ-006 en  in  NCH: per-channel run enable.
REQ-007 cfg_we  in  1: one-cycle divisor/mode write strobe.
REQ-008 cfg_ch  in  max(1,$clog2(NCH)): target channel of the write.
REQ-009 cfg_div  in  W: new divisor N (period in clk cycles).
REQ-010 cfg_mode  in  1: 0 = square output, 1 = pulse output.
REQ-011 div_clk  out  NCH: registered divided output per channel.
REQ-012 tick  out  NCH: registered one-cycle strobe at each period start.
REQ-013 pend  out  NCH: high while a written divisor/mode awaits its apply point.

Function
REQ-014 Each channel SHALL hold active divisor D, active mode M, counter cnt (W bits), pending D/M and pending flag.
REQ-015 Effective divisor SHALL be max(D,2); D=0 SHALL halt the channel (cnt=0, div_clk=0, tick=0).
REQ-016 While en[i]=1 and D!=0: cnt<D-1 -> cnt+1, tick<=0; cnt==D-1 ("wrap") -> cnt<=0, tick<=1.
REQ-017 First tick SHALL be visible after the D-th rising edge with en sampled high from cnt=0; thereafter period exactly D cycles.
REQ-018 Square mode: div_clk SHALL be high for next-cnt values 0..(D>>1)-1, low otherwise; rises with tick; odd D gives shorter high phase.
REQ-019 Pulse mode: div_clk SHALL equal tick.
REQ-020 en[i]=0 SHALL force cnt=0, div_clk=0, tick=0 on the next edge.
REQ-021 cfg_we with cfg_ch>=NCH SHALL be ignored.
REQ-022 Write to an enabled channel SHALL store pending D/M, set pend; applied at next wrap, pend cleared same edge.
REQ-023 Write in the same cycle as a wrap SHALL be applied at that wrap (new D governs the next period).
REQ-024 Multiple writes before a wrap: last write wins.
REQ-025 Write to a disabled or halted channel SHALL apply on the next edge; pend never set.
REQ-026 Channels SHALL be fully independent; no cross-channel interaction except REQ-031.

Reset
REQ-027 rst_n=0 at an edge SHALL set all D=RST_DIV, M=0, cnt=0, pending cleared, div_clk=0, tick=0, pend=0.
REQ-028 Reset mid-period SHALL discard pending writes; counting restarts from cnt=0 after release.

Configuration
REQ-029 Macro CLK_DIV_BANK_SYNC_EN SHALL add input port sync (1 bit).
REQ-030 Without the macro the port SHALL be absent and behaviour is as above.
REQ-031 With the macro, sync=1 SHALL force a wrap on every enabled, non-halted channel that edge (cnt<=0, tick<=1, pending applied, square div_clk<=1); channels become phase-aligned.

Structure
REQ-032 Package clk_div_pkg SHALL hold the mode enum (MODE_SQUARE=0, MODE_PULSE=1) and the NCH/W bound constants.
REQ-033 Sub-module clk_div_chan SHALL implement one channel; clk_div_bank SHALL instantiate NCH copies and decode cfg_ch.

Verification
REQ-034 Reset, en=1 ch0, default RST_DIV -> first tick[0] after edge 16384, div_clk[0] high 8192 / low 8192.
REQ-035 Ch1 D=5 square -> tick every 5 cycles, div_clk high 2, low 3.
REQ-036 Ch2 D=4 running, write D=7 mid-period -> pend[2]=1 until next wrap, old period completes, then period 7.
REQ-037 Write D=3 to ch3 coinciding with wrap -> next period 3; second write before wrap -> only last value used.
REQ-038 D=0 and D=1 writes -> channel halted vs. period 2; cfg_ch=NCH write -> no channel changes.
REQ-039 With CLK_DIV_BANK_SYNC_EN, ch0 D=6, ch1 D=9 free-running, pulse sync -> both tick next cycle, counters aligned.

Source files
------------

// File: rtl/clk_div_pkg.sv
//------------------------------------------------------------------------------
// Module      : clk_div_pkg
// Description : Shared types and bounds for the clock divider bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned NCH_MIN = 1;
  localparam int unsigned NCH_MAX = 16;
  localparam int unsigned W_MIN   = 2;
  localparam int unsigned W_MAX   = 32;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned chw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
//------------------------------------------------------------------------------
// Module      : clk_div_chan
// Description : One divider channel: counter, square/pulse output, deferred
//               divisor/mode update applied at the period wrap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_chan import clk_div_pkg::*; #(
  parameter int W       = 16,
  parameter int RST_DIV = 16384
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_sync,
  input  logic         i_we,
  input  logic [W-1:0] i_div,
  input  mode_e        i_mode,
  output logic         o_div_clk,
  output logic         o_tick,
  output logic         o_pend
);

  logic [W-1:0] r_div;
  logic [W-1:0] r_pdiv;
  logic [W-1:0] r_cnt;
  mode_e        r_mode;
  mode_e        r_pmode;
  logic         r_pend;
  logic         r_div_clk;
  logic         r_tick;

  logic [W-1:0] w_last;
  logic [W-1:0] w_half;
  logic [W-1:0] w_cnt_inc;
  logic         w_halted;
  logic         w_wrap;

  // Divisor 1 behaves as 2, so last count and high-phase length clamp to 1.
  always_comb begin
    w_halted  = (r_div == '0);
    w_last    = (r_div < W'(2)) ? W'(1) : (r_div - W'(1));
    w_half    = (r_div < W'(2)) ? W'(1) : (r_div >> 1);
    w_cnt_inc = r_cnt + W'(1);
    w_wrap    = i_sync || (r_cnt >= w_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= W'(RST_DIV);
      r_mode    <= MODE_SQUARE;
      r_pdiv    <= '0;
      r_pmode   <= MODE_SQUARE;
      r_pend    <= 1'b0;
      r_cnt     <= '0;
      r_div_clk <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!i_en || w_halted) begin
      r_cnt     <= '0;
      r_div_clk <= 1'b0;
      r_tick    <= 1'b0;
      r_pend    <= 1'b0;
      if (i_we) begin
        r_div  <= i_div;
        r_mode <= i_mode;
      end else if (r_pend) begin
        r_div  <= r_pdiv;
        r_mode <= r_pmode;
      end
    end else if (w_wrap) begin
      // Next count is 0, which is inside the high phase for either mode.
      r_cnt     <= '0;
      r_tick    <= 1'b1;
      r_div_clk <= 1'b1;
      r_pend    <= 1'b0;
      if (i_we) begin
        r_div  <= i_div;
        r_mode <= i_mode;
      end else if (r_pend) begin
        r_div  <= r_pdiv;
        r_mode <= r_pmode;
      end
    end else begin
      r_cnt     <= w_cnt_inc;
      r_tick    <= 1'b0;
      r_div_clk <= (r_mode == MODE_SQUARE) && (w_cnt_inc < w_half);
      if (i_we) begin
        r_pdiv  <= i_div;
        r_pmode <= i_mode;
        r_pend  <= 1'b1;
      end
    end
  end

  assign o_div_clk = r_div_clk;
  assign o_tick    = r_tick;
  assign o_pend    = r_pend;

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
//------------------------------------------------------------------------------
// Module      : clk_div_bank
// Description : Bank of NCH independent programmable clock dividers.
//               Define CLK_DIV_BANK_SYNC_EN to add the phase-align input sync.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_bank import clk_div_pkg::*; #(
  parameter int NCH     = 4,
  parameter int W       = 16,
  parameter int RST_DIV = 16384
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        en,
  input  logic                  cfg_we,
  input  logic [chw(NCH)-1:0]   cfg_ch,
  input  logic [W-1:0]          cfg_div,
  input  logic                  cfg_mode,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic                  sync,
`endif
  output logic [NCH-1:0]        div_clk,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0]        pend
);

  localparam int CHW = chw(NCH);

  logic w_sync;

`ifdef CLK_DIV_BANK_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Out-of-range cfg_ch values match no channel and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic w_we;
      assign w_we = cfg_we && (cfg_ch == CHW'(gi));

      clk_div_chan #(
        .W       (W),
        .RST_DIV (RST_DIV)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (en[gi]),
        .i_sync    (w_sync),
        .i_we      (w_we),
        .i_div     (cfg_div),
        .i_mode    (mode_e'(cfg_mode)),
        .o_div_clk (div_clk[gi]),
        .o_tick    (tick[gi]),
        .o_pend    (pend[gi])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
//------------------------------------------------------------------------------
// Module      : tb_clk_div_bank
// Description : Directed self-checking bench for clk_div_bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_bank;

  localparam int NCH = 5;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           cfg_we = 1'b0;
  logic [2:0]     cfg_ch = '0;
  logic [W-1:0]   cfg_div = '0;
  logic           cfg_mode = 1'b0;
`ifdef CLK_DIV_BANK_SYNC_EN
  logic           sync = 1'b0;
`endif
  logic [NCH-1:0] div_clk;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NCH     (NCH),
    .W       (W),
    .RST_DIV (16384)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
`ifdef CLK_DIV_BANK_SYNC_EN
    .sync     (sync),
`endif
    .div_clk  (div_clk),
    .tick     (tick),
    .pend     (pend)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int d, input logic m);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_div  = W'(d);
    cfg_mode = m;
    step(1);
    cfg_we   = 1'b0;
  endtask

  // Counts consecutive samples at the given level, bounded by limit.
  task automatic measure_run(input int ch, input logic level, input int limit, output int n);
    n = 0;
    while (div_clk[ch] === level && n < limit) begin
      n++;
      step(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    n_vec++; if (div_clk !== 5'b0) begin n_err++; $display("FAIL reset_div_clk got=%b exp=%b", div_clk, 5'b0); end
    n_vec++; if (tick !== 5'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=%b", tick, 5'b0); end
    n_vec++; if (pend !== 5'b0) begin n_err++; $display("FAIL reset_pend got=%b exp=%b", pend, 5'b0); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_default_div;
    int n;
    en[0] = 1'b1;
    step(16383);
    n_vec++; if (tick[0] !== 1'b0) begin n_err++; $display("FAIL def_pre_tick got=%b exp=0", tick[0]); end
    step(1);
    n_vec++; if (tick[0] !== 1'b1) begin n_err++; $display("FAIL def_first_tick got=%b exp=1", tick[0]); end
    measure_run(0, 1'b1, 20000, n);
    n_vec++; if (n !== 8192) begin n_err++; $display("FAIL def_high got=%0d exp=8192", n); end
    measure_run(0, 1'b0, 20000, n);
    n_vec++; if (n !== 8192) begin n_err++; $display("FAIL def_low got=%0d exp=8192", n); end
    n_vec++; if (tick[0] !== 1'b1) begin n_err++; $display("FAIL def_second_tick got=%b exp=1", tick[0]); end
    en[0] = 1'b0;
    step(1);
    n_vec++; if ({div_clk[0], tick[0]} !== 2'b00) begin n_err++; $display("FAIL def_disable got=%b exp=00", {div_clk[0], tick[0]}); end
  endtask

  task automatic test_square5;
    int n;
    cfg_write(1, 5, 1'b0);
    n_vec++; if (pend[1] !== 1'b0) begin n_err++; $display("FAIL sq_pend_disabled got=%b exp=0", pend[1]); end
    en[1] = 1'b1;
    step(4);
    n_vec++; if (tick[1] !== 1'b0) begin n_err++; $display("FAIL sq_pre_tick got=%b exp=0", tick[1]); end
    step(1);
    n_vec++; if (tick[1] !== 1'b1) begin n_err++; $display("FAIL sq_tick got=%b exp=1", tick[1]); end
    measure_run(1, 1'b1, 50, n);
    n_vec++; if (n !== 2) begin n_err++; $display("FAIL sq_high got=%0d exp=2", n); end
    measure_run(1, 1'b0, 50, n);
    n_vec++; if (n !== 3) begin n_err++; $display("FAIL sq_low got=%0d exp=3", n); end
    n_vec++; if (tick[1] !== 1'b1) begin n_err++; $display("FAIL sq_period got=%b exp=1", tick[1]); end
  endtask

  task automatic test_pending;
    cfg_write(2, 4, 1'b0);
    en[2] = 1'b1;
    step(4);
    n_vec++; if (tick[2] !== 1'b1) begin n_err++; $display("FAIL pd_tick4 got=%b exp=1", tick[2]); end
    step(1);
    cfg_write(2, 7, 1'b0);
    n_vec++; if (pend[2] !== 1'b1) begin n_err++; $display("FAIL pd_pend_set got=%b exp=1", pend[2]); end
    step(1);
    n_vec++; if ({pend[2], tick[2]} !== 2'b10) begin n_err++; $display("FAIL pd_hold got=%b exp=10", {pend[2], tick[2]}); end
    step(1);
    n_vec++; if ({pend[2], tick[2]} !== 2'b01) begin n_err++; $display("FAIL pd_apply got=%b exp=01", {pend[2], tick[2]}); end
    step(6);
    n_vec++; if (tick[2] !== 1'b0) begin n_err++; $display("FAIL pd_pre7 got=%b exp=0", tick[2]); end
    step(1);
    n_vec++; if (tick[2] !== 1'b1) begin n_err++; $display("FAIL pd_tick7 got=%b exp=1", tick[2]); end
  endtask

  task automatic test_wrap_write;
    cfg_write(3, 4, 1'b0);
    en[3] = 1'b1;
    step(4);
    step(3);
    cfg_write(3, 3, 1'b0);
    n_vec++; if ({pend[3], tick[3]} !== 2'b01) begin n_err++; $display("FAIL ww_coincide got=%b exp=01", {pend[3], tick[3]}); end
    step(2);
    n_vec++; if (tick[3] !== 1'b0) begin n_err++; $display("FAIL ww_pre3 got=%b exp=0", tick[3]); end
    step(1);
    n_vec++; if (tick[3] !== 1'b1) begin n_err++; $display("FAIL ww_tick3 got=%b exp=1", tick[3]); end
    cfg_write(3, 6, 1'b0);
    cfg_write(3, 2, 1'b0);
    n_vec++; if (pend[3] !== 1'b1) begin n_err++; $display("FAIL ww_pend2 got=%b exp=1", pend[3]); end
    step(1);
    n_vec++; if ({pend[3], tick[3]} !== 2'b01) begin n_err++; $display("FAIL ww_wrap got=%b exp=01", {pend[3], tick[3]}); end
    step(1);
    n_vec++; if (tick[3] !== 1'b0) begin n_err++; $display("FAIL ww_pre2 got=%b exp=0", tick[3]); end
    step(1);
    n_vec++; if (tick[3] !== 1'b1) begin n_err++; $display("FAIL ww_last_wins got=%b exp=1", tick[3]); end
  endtask

  task automatic test_pulse;
    logic exp;
    en[2] = 1'b0;
    step(1);
    cfg_write(2, 3, 1'b1);
    en[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      exp = (k % 3 == 0);
      n_vec++; if ({div_clk[2], tick[2]} !== {exp, exp}) begin n_err++; $display("FAIL pulse_k%0d got=%b exp=%b", k, {div_clk[2], tick[2]}, {exp, exp}); end
    end
  endtask

  task automatic test_halt_range;
    cfg_write(4, 1, 1'b0);
    en[4] = 1'b1;
    step(1);
    n_vec++; if (tick[4] !== 1'b0) begin n_err++; $display("FAIL d1_pre got=%b exp=0", tick[4]); end
    step(1);
    n_vec++; if ({div_clk[4], tick[4]} !== 2'b11) begin n_err++; $display("FAIL d1_tick got=%b exp=11", {div_clk[4], tick[4]}); end
    step(1);
    n_vec++; if ({div_clk[4], tick[4]} !== 2'b00) begin n_err++; $display("FAIL d1_low got=%b exp=00", {div_clk[4], tick[4]}); end
    cfg_write(4, 0, 1'b0);
    n_vec++; if ({pend[4], tick[4]} !== 2'b01) begin n_err++; $display("FAIL d0_apply got=%b exp=01", {pend[4], tick[4]}); end
    step(5);
    n_vec++; if ({div_clk[4], tick[4]} !== 2'b00) begin n_err++; $display("FAIL d0_halted got=%b exp=00", {div_clk[4], tick[4]}); end
    cfg_write(4, 3, 1'b0);
    n_vec++; if (pend[4] !== 1'b0) begin n_err++; $display("FAIL halt_wr_pend got=%b exp=0", pend[4]); end
    en[4] = 1'b0;
    step(1);
    cfg_write(5, 2, 1'b1);
    n_vec++; if (pend !== 5'b0) begin n_err++; $display("FAIL range_pend got=%b exp=%b", pend, 5'b0); end
    en[4] = 1'b1;
    step(2);
    n_vec++; if (tick[4] !== 1'b0) begin n_err++; $display("FAIL range_pre got=%b exp=0", tick[4]); end
    step(1);
    n_vec++; if (tick[4] !== 1'b1) begin n_err++; $display("FAIL range_keep3 got=%b exp=1", tick[4]); end
  endtask

`ifdef CLK_DIV_BANK_SYNC_EN
  task automatic test_sync;
    en[1:0] = 2'b00;
    step(1);
    cfg_write(0, 6, 1'b0);
    cfg_write(1, 9, 1'b0);
    en[1:0] = 2'b11;
    step(4);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    n_vec++; if (tick[1:0] !== 2'b11) begin n_err++; $display("FAIL sync_both got=%b exp=11", tick[1:0]); end
    step(6);
    n_vec++; if (tick[1:0] !== 2'b01) begin n_err++; $display("FAIL sync_ch0_6 got=%b exp=01", tick[1:0]); end
    step(3);
    n_vec++; if (tick[1] !== 1'b1) begin n_err++; $display("FAIL sync_ch1_9 got=%b exp=1", tick[1]); end
  endtask
`endif

  task automatic test_reset_mid;
    rst_n = 1'b0;
    en = '0;
    step(1);
    rst_n = 1'b1;
    en[0] = 1'b1;
    step(3);
    cfg_write(0, 5, 1'b0);
    n_vec++; if (pend[0] !== 1'b1) begin n_err++; $display("FAIL rm_pend got=%b exp=1", pend[0]); end
    rst_n = 1'b0;
    step(1);
    n_vec++; if ({pend[0], tick[0], div_clk[0]} !== 3'b000) begin n_err++; $display("FAIL rm_reset got=%b exp=000", {pend[0], tick[0], div_clk[0]}); end
    rst_n = 1'b1;
    step(5);
    n_vec++; if (tick[0] !== 1'b0) begin n_err++; $display("FAIL rm_discard got=%b exp=0", tick[0]); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_default_div();
    test_square5();
    test_pending();
    test_wrap_write();
    test_pulse();
    test_halt_range();
`ifdef CLK_DIV_BANK_SYNC_EN
    test_sync();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
